// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS MEM stage: opcodes, control bit positions,
// FSM encoding and access-size helpers.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam int WB_REGWRITE = 0;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Unknown memory opcodes fall back to word accesses.
  function automatic size_e op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    op_signed = (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: misalignment, byte enables, store replication
// and load extraction with sign/zero extension (little-endian).
module mem_align
  import mips_mem_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  size_e       size_s;
  logic        sign_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    size_s     = op_size(op_i);
    sign_s     = op_signed(op_i);
    byte_s     = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_s     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    misalign_o = 1'b0;
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    ldata_o    = rdata_i;
    case (size_s)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        ldata_o = {{24{sign_s & byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        misalign_o = addr_lo_i[0];
        be_o       = 4'b0011 << addr_lo_i;
        wdata_o    = {2{wdata_i[15:0]}};
        ldata_o    = {{16{sign_s & half_s[15]}}, half_s};
      end
      SZ_WORD: begin
        misalign_o = |addr_lo_i;
      end
      default: begin
        misalign_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: EX/MEM register plus IDLE/ACCESS/DONE data-memory FSM.
// Optional watchdog abort of a stuck access: define DMEM_TIMEOUT_EN.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  EX_WB,
  input  logic [1:0]  EX_M,
  input  logic [5:0]  EX_Opcode,
  input  logic [31:0] EX_ALU_RESULT,
  input  logic [31:0] EX_WDATA,
  input  logic [4:0]  EX_RD,
  input  logic [31:0] EX_PC_4,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_READY,
  input  logic [31:0] DMEM_RDATA,
  output logic        MEM_STALL,
  output logic        MEM_ALIGN_ERR,
  output logic [2:0]  WB_MEM,
  output logic [5:0]  MEM_Opcode,
  output logic [31:0] MEM_ALU_RESULT,
  output logic [31:0] MEM_RD_DATA,
  output logic [4:0]  MEM_RD,
  output logic [31:0] MEM_PC_4
);

  if ((1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  logic [2:0]  wb_q;
  logic [1:0]  m_q;
  logic [5:0]  op_q;
  logic [31:0] alu_q, wdata_q, pc4_q;
  logic [4:0]  rd_q;
  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mem_op_s, misalign_s, stall_s;
  logic [3:0]  be_s;
  logic [31:0] st_data_s, ldata_s;
`ifdef DMEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
`endif

  assign mem_op_s = |m_q;

  mem_align u_align (
    .op_i      (op_q),
    .addr_lo_i (alu_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (DMEM_RDATA),
    .misalign_o(misalign_s),
    .be_o      (be_s),
    .wdata_o   (st_data_s),
    .ldata_o   (ldata_s)
  );

  // State register and EX/MEM capture; the pipeline register holds while stalled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      wb_q    <= 3'b000;
      m_q     <= 2'b00;
      op_q    <= 6'h00;
      alu_q   <= 32'h0;
      wdata_q <= 32'h0;
      rd_q    <= 5'd0;
      pc4_q   <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
`endif
      if (!stall_s) begin
        wb_q    <= EX_WB;
        m_q     <= EX_M;
        op_q    <= EX_Opcode;
        alu_q   <= EX_ALU_RESULT;
        wdata_q <= EX_WDATA;
        rd_q    <= EX_RD;
        pc4_q   <= EX_PC_4;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    abort_d = abort_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s && !misalign_s) begin
          state_d = ST_ACCESS;
`ifdef DMEM_TIMEOUT_EN
          cnt_d   = '0;
          abort_d = 1'b0;
`endif
        end else if (mem_op_s) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (DMEM_READY) begin
          rdata_d = m_q[M_MEMREAD] ? ldata_s : 32'h0;
          state_d = ST_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
`endif
        else begin
          state_d = ST_ACCESS;
`ifdef DMEM_TIMEOUT_EN
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef DMEM_TIMEOUT_EN
        abort_d = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; a memory op sitting in IDLE is always a bubble (stall or misalign).
  always_comb begin
    stall_s     = 1'b0;
    DMEM_REQ    = 1'b0;
    DMEM_WE     = 1'b0;
    DMEM_ADDR   = 32'h0;
    DMEM_BE     = 4'h0;
    DMEM_WDATA  = 32'h0;
    WB_MEM      = wb_q;
    MEM_RD_DATA = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s) begin
          stall_s = !misalign_s;
          WB_MEM  = 3'b000;
        end else begin
          WB_MEM = wb_q;
        end
      end
      ST_ACCESS: begin
        stall_s    = 1'b1;
        DMEM_REQ   = 1'b1;
        DMEM_WE    = m_q[M_MEMWRITE];
        DMEM_ADDR  = {alu_q[31:2], 2'b00};
        DMEM_BE    = be_s;
        DMEM_WDATA = st_data_s;
        WB_MEM     = 3'b000;
      end
      ST_DONE: begin
        MEM_RD_DATA = rdata_q;
`ifdef DMEM_TIMEOUT_EN
        if (abort_q) begin
          WB_MEM = 3'b000;
        end else begin
          WB_MEM = wb_q;
        end
`endif
      end
      default: WB_MEM = 3'b000;
    endcase
  end

  assign MEM_STALL      = stall_s;
  assign MEM_ALIGN_ERR  = err_q;
  assign MEM_Opcode     = op_q;
  assign MEM_ALU_RESULT = alu_q;
  assign MEM_RD         = rd_q;
  assign MEM_PC_4       = pc4_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table + scoreboard,
// plus hand sequences for reset, reset mid-access and (optionally) timeout.
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [2:0]  EX_WB;
  logic [1:0]  EX_M;
  logic [5:0]  EX_Opcode;
  logic [31:0] EX_ALU_RESULT, EX_WDATA, EX_PC_4;
  logic [4:0]  EX_RD;
  logic        DMEM_REQ, DMEM_WE, DMEM_READY;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic [3:0]  DMEM_BE;
  logic        MEM_STALL, MEM_ALIGN_ERR;
  logic [2:0]  WB_MEM;
  logic [5:0]  MEM_Opcode;
  logic [31:0] MEM_ALU_RESULT, MEM_RD_DATA, MEM_PC_4;
  logic [4:0]  MEM_RD;

  always #5 CLK = ~CLK;

  mem_access_stage dut (
    .CLK(CLK), .RESET(RESET),
    .EX_WB(EX_WB), .EX_M(EX_M), .EX_Opcode(EX_Opcode),
    .EX_ALU_RESULT(EX_ALU_RESULT), .EX_WDATA(EX_WDATA),
    .EX_RD(EX_RD), .EX_PC_4(EX_PC_4),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_BE(DMEM_BE), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_READY(DMEM_READY), .DMEM_RDATA(DMEM_RDATA),
    .MEM_STALL(MEM_STALL), .MEM_ALIGN_ERR(MEM_ALIGN_ERR),
    .WB_MEM(WB_MEM), .MEM_Opcode(MEM_Opcode),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_RD_DATA(MEM_RD_DATA),
    .MEM_RD(MEM_RD), .MEM_PC_4(MEM_PC_4)
  );

  typedef struct {
    logic [2:0]  wb;
    logic [1:0]  m;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          delay;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdd;
    logic [2:0]  exp_wb;
    int          exp_stall;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [2:0]  wb;
    logic [5:0]  op;
    logic [31:0] alu;
    logic [31:0] rdd;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } sb_t;

  sb_t   sbq[$];
  vec_t  vecs[17];
  int    checks   = 0;
  int    failures = 0;
  logic  err_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] wb, input logic [1:0] m, input logic [5:0] op,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] pc4);
    EX_WB = wb; EX_M = m; EX_Opcode = op; EX_ALU_RESULT = alu;
    EX_WDATA = wd; EX_RD = rd; EX_PC_4 = pc4;
  endtask

  // Called at a negedge; returns at the negedge where the instruction's result is visible.
  task automatic run_vec(input vec_t v, input int idx);
    int   stalls, reqs;
    bit   done, first;
    sb_t  e, got;
    logic [31:0] pc4;
    pc4 = 32'h0000_1000 + 32'(idx * 4);
    drive(v.wb, v.m, v.op, v.addr, v.wdata, v.rd, pc4);
    e.wb = v.exp_wb; e.op = v.op; e.alu = v.addr; e.rdd = v.exp_rdd; e.pc4 = pc4; e.rd = v.rd;
    sbq.push_back(e);
    @(posedge CLK); @(negedge CLK);
    stalls = 0; reqs = 0; first = 1'b1; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      chk($sformatf("v%0d_align_err", idx), 32'(MEM_ALIGN_ERR), first ? 32'(err_pending) : 32'h0);
      first = 1'b0;
      if (MEM_STALL) begin
        stalls++;
        chk($sformatf("v%0d_wb_bubble", idx), 32'(WB_MEM), 32'h0);
        if (DMEM_REQ) begin
          reqs++;
          if (reqs == 1) begin
            chk($sformatf("v%0d_addr", idx), DMEM_ADDR, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d_we", idx), 32'(DMEM_WE), 32'(v.exp_we));
            if (v.exp_we) begin
              chk($sformatf("v%0d_be", idx), 32'(DMEM_BE), 32'(v.exp_be));
              chk($sformatf("v%0d_wdata", idx), DMEM_WDATA, v.exp_wdata);
            end
          end
          DMEM_READY = (reqs == v.delay);
          DMEM_RDATA = v.rdata;
        end else begin
          DMEM_READY = 1'b0;
        end
        @(posedge CLK); @(negedge CLK);
      end else begin
        DMEM_READY = 1'b0;
        done = 1'b1;
        chk($sformatf("v%0d_req_idle", idx), 32'(DMEM_REQ), 32'h0);
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL v%0d_scoreboard actual=empty expected=entry", idx);
        end else begin
          got = sbq.pop_front();
          chk($sformatf("v%0d_wb_mem", idx), 32'(WB_MEM), 32'(got.wb));
          chk($sformatf("v%0d_rd_data", idx), MEM_RD_DATA, got.rdd);
          chk($sformatf("v%0d_rd", idx), 32'(MEM_RD), 32'(got.rd));
          chk($sformatf("v%0d_alu", idx), MEM_ALU_RESULT, got.alu);
          chk($sformatf("v%0d_opcode", idx), 32'(MEM_Opcode), 32'(got.op));
          chk($sformatf("v%0d_pc4", idx), MEM_PC_4, got.pc4);
        end
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL v%0d_timeout actual=stalled expected=complete", idx);
    end
    chk($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(v.exp_stall));
    chk($sformatf("v%0d_req_seen", idx), 32'(reqs > 0), 32'(v.exp_req));
    err_pending = v.exp_err;
  endtask

  initial begin
    // wb, m, op, addr, wdata, rdata, rd, delay, req, we, be, st_wdata, rd_data, exp_wb, stall, err
    vecs[0]  = '{3'b011, 2'b10, 6'h20, 32'h103, 32'h0, 32'h80FF_1234, 5'd8, 2, 1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80, 3'b011, 3, 1'b0};
    vecs[1]  = '{3'b011, 2'b10, 6'h24, 32'h103, 32'h0, 32'h80FF_1234, 5'd9, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_0080, 3'b011, 2, 1'b0};
    vecs[2]  = '{3'b011, 2'b10, 6'h25, 32'h102, 32'h0, 32'h80FF_1234, 5'd10, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_80FF, 3'b011, 2, 1'b0};
    vecs[3]  = '{3'b011, 2'b10, 6'h21, 32'h102, 32'h0, 32'h80FF_1234, 5'd11, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF_80FF, 3'b011, 2, 1'b0};
    vecs[4]  = '{3'b011, 2'b10, 6'h20, 32'h101, 32'h0, 32'h80FF_1234, 5'd12, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_0012, 3'b011, 2, 1'b0};
    vecs[5]  = '{3'b011, 2'b10, 6'h21, 32'h100, 32'h0, 32'h80FF_1234, 5'd13, 2, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_1234, 3'b011, 3, 1'b0};
    vecs[6]  = '{3'b011, 2'b10, 6'h23, 32'h104, 32'h0, 32'hDEAD_BEEF, 5'd14, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF, 3'b011, 2, 1'b0};
    vecs[7]  = '{3'b100, 2'b01, 6'h28, 32'h201, 32'h0000_00AB, 32'hFFFF_FFFF, 5'd0, 1, 1'b1, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0, 3'b100, 2, 1'b0};
    vecs[8]  = '{3'b000, 2'b01, 6'h29, 32'h302, 32'h1234_CDEF, 32'hFFFF_FFFF, 5'd0, 2, 1'b1, 1'b1, 4'b1100, 32'hCDEF_CDEF, 32'h0, 3'b000, 3, 1'b0};
    vecs[9]  = '{3'b000, 2'b01, 6'h2B, 32'h400, 32'hCAFE_F00D, 32'hFFFF_FFFF, 5'd0, 1, 1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0, 3'b000, 2, 1'b0};
    vecs[10] = '{3'b001, 2'b01, 6'h29, 32'h303, 32'h0000_1111, 32'h0, 5'd1, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 0, 1'b1};
    vecs[11] = '{3'b011, 2'b10, 6'h23, 32'h402, 32'h0, 32'h0, 5'd2, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 0, 1'b1};
    vecs[12] = '{3'b001, 2'b00, 6'h00, 32'h1234_5678, 32'h0, 32'h0, 5'd3, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b001, 0, 1'b0};
    vecs[13] = '{3'b011, 2'b10, 6'h3F, 32'h108, 32'h0, 32'h1122_3344, 5'd4, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h1122_3344, 3'b011, 2, 1'b0};
    vecs[14] = '{3'b011, 2'b10, 6'h25, 32'h101, 32'h0, 32'h0, 5'd5, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 0, 1'b1};
    vecs[15] = '{3'b000, 2'b01, 6'h28, 32'h203, 32'h0000_005A, 32'hFFFF_FFFF, 5'd0, 1, 1'b1, 1'b1, 4'b1000, 32'h5A5A_5A5A, 32'h0, 3'b000, 2, 1'b0};
    vecs[16] = '{3'b000, 2'b00, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 0, 1'b0};

    // Reset with random inputs, including a READY pulse.
    RESET = 1'b1;
    DMEM_READY = 1'($urandom);
    DMEM_RDATA = $urandom;
    drive(3'($urandom), 2'($urandom), 6'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    chk("rst_req", 32'(DMEM_REQ), 32'h0);
    chk("rst_stall", 32'(MEM_STALL), 32'h0);
    chk("rst_we", 32'(DMEM_WE), 32'h0);
    chk("rst_addr", DMEM_ADDR, 32'h0);
    chk("rst_be", 32'(DMEM_BE), 32'h0);
    chk("rst_wdata", DMEM_WDATA, 32'h0);
    chk("rst_err", 32'(MEM_ALIGN_ERR), 32'h0);
    chk("rst_wb", 32'(WB_MEM), 32'h0);
    chk("rst_op", 32'(MEM_Opcode), 32'h0);
    chk("rst_alu", MEM_ALU_RESULT, 32'h0);
    chk("rst_rdd", MEM_RD_DATA, 32'h0);
    chk("rst_rd", 32'(MEM_RD), 32'h0);
    chk("rst_pc4", MEM_PC_4, 32'h0);
    RESET = 1'b0;
    DMEM_READY = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // Reset while in ACCESS, READY arriving with and after the reset.
    drive(3'b011, 2'b10, 6'h23, 32'h500, 32'h0, 5'd3, 32'h2000);
    @(posedge CLK); @(negedge CLK);
    chk("midrst_idle_stall", 32'(MEM_STALL), 32'h1);
    @(posedge CLK); @(negedge CLK);
    chk("midrst_access_req", 32'(DMEM_REQ), 32'h1);
    RESET = 1'b1;
    DMEM_READY = 1'b1;
    DMEM_RDATA = 32'h55AA_55AA;
    drive(3'b000, 2'b00, 6'h00, 32'h0, 32'h0, 5'd0, 32'h0);
    @(posedge CLK); @(negedge CLK);
    chk("midrst_req_drop", 32'(DMEM_REQ), 32'h0);
    chk("midrst_stall", 32'(MEM_STALL), 32'h0);
    chk("midrst_wb", 32'(WB_MEM), 32'h0);
    chk("midrst_rdd", MEM_RD_DATA, 32'h0);
    RESET = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("late_ready_req", 32'(DMEM_REQ), 32'h0);
    chk("late_ready_stall", 32'(MEM_STALL), 32'h0);
    chk("late_ready_wb", 32'(WB_MEM), 32'h0);
    chk("late_ready_rdd", MEM_RD_DATA, 32'h0);
    DMEM_READY = 1'b0;
    err_pending = 1'b0;
    run_vec(vecs[6], 20);

`ifdef DMEM_TIMEOUT_EN
    begin
      int  reqs;
      bit  fin;
      reqs = 0; fin = 1'b0;
      drive(3'b011, 2'b10, 6'h23, 32'h600, 32'h0, 5'd7, 32'h3000);
      @(posedge CLK); @(negedge CLK);
      drive(3'b000, 2'b00, 6'h00, 32'h0, 32'h0, 5'd0, 32'h0);
      for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
        if (MEM_STALL) begin
          if (DMEM_REQ) reqs++;
          @(posedge CLK); @(negedge CLK);
        end else begin
          fin = 1'b1;
        end
      end
      chk("timeout_finished", 32'(fin), 32'h1);
      chk("timeout_access_cycles", 32'(reqs), 32'd16);
      chk("timeout_wb", 32'(WB_MEM), 32'h0);
      chk("timeout_err", 32'(MEM_ALIGN_ERR), 32'h1);
      @(posedge CLK); @(negedge CLK);
      chk("timeout_err_pulse", 32'(MEM_ALIGN_ERR), 32'h0);
    end
`endif

    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
